// File: rtl/uart_tx_mmio_if.sv
// uart_tx_mmio_if: store-path bus and status signals between the core and the UART transmitter
// wr_en/wr_data/clr_ovf: core -> transmitter strobes; uart_rxd_out: serial line to host
// full/empty/level/busy/overflow: transmitter status polled by the core
interface uart_tx_mmio_if #(
    parameter int FIFO_DEPTH = 16
);
    localparam int LW = $clog2(FIFO_DEPTH + 1);
    logic          wr_en;
    logic [7:0]    wr_data;
    logic          clr_ovf;
    logic          uart_rxd_out;
    logic          full;
    logic          empty;
    logic [LW-1:0] level;
    logic          busy;
    logic          overflow;
    modport master (
        output wr_en, wr_data, clr_ovf,
        input  uart_rxd_out, full, empty, level, busy, overflow
    );
    modport slave (
        input  wr_en, wr_data, clr_ovf,
        output uart_rxd_out, full, empty, level, busy, overflow
    );
endinterface

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: byte FIFO feeding an 8N1 LSB-first serializer, with full/empty/level/overflow status
// CLK100MHZ: system clock; ck_rst: asynchronous active-low reset
// bus: slave side of uart_tx_mmio_if (store strobe, overflow clear, serial line, status)
module uart_tx_mmio #(
    parameter int CLK_HZ     = 100000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input logic           CLK100MHZ,
    input logic           ck_rst,
    uart_tx_mmio_if.slave bus
);
    localparam int CPB = CLK_HZ / BAUD;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam int CW = CPB > 1 ? $clog2(CPB) : 1;
    localparam logic [CW-1:0] CMAX = CW'(CPB - 1);
    localparam logic [LW-1:0] LFULL = LW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q, state_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wp_q, rp_q;
    logic [LW-1:0] level_q, level_d;
    logic          full_q, empty_q, ovf_q, ovf_d, line_q, line_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bit_q, bit_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          push, pop, tick;

    // full is the registered flag, so a pop in the same cycle cannot make room for this write
    assign push = bus.wr_en && !full_q;
    assign tick = cnt_q == CMAX;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        cnt_d   = tick ? '0 : cnt_q + 1'b1;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                pop = !empty_q;
                state_d = empty_q ? IDLE : START;
            end
            START: if (tick) begin
                state_d = DATA;
                bit_d = '0;
            end
            DATA: if (tick) begin
                shift_d = shift_q >> 1;
                bit_d = bit_q + 3'd1;
                state_d = bit_q == 3'd7 ? STOP : DATA;
            end
            STOP: if (tick) begin
                pop = !empty_q;
                state_d = empty_q ? IDLE : START;
            end
            default: state_d = IDLE;
        endcase
        shift_d = pop ? mem_q[rp_q] : shift_d;
        // line is registered from the next state so it changes exactly on the state edge
        line_d  = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : 1'b1;
        level_d = level_q + LW'(push) - LW'(pop);
        ovf_d   = (bus.wr_en && full_q) || (ovf_q && !bus.clr_ovf);
    end

    always_ff @(posedge CLK100MHZ or negedge ck_rst) begin
        if (!ck_rst) begin
            state_q <= IDLE;
            wp_q    <= '0;
            rp_q    <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            ovf_q   <= 1'b0;
            line_q  <= 1'b1;
            shift_q <= '0;
            bit_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wp_q    <= wp_q + AW'(push);
            rp_q    <= rp_q + AW'(pop);
            level_q <= level_d;
            full_q  <= level_d == LFULL;
            empty_q <= level_d == '0;
            ovf_q   <= ovf_d;
            line_q  <= line_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge CLK100MHZ) begin
        if (push) mem_q[wp_q] <= bus.wr_data;
    end

    assign bus.uart_rxd_out = line_q;
    assign bus.full         = full_q;
    assign bus.empty        = empty_q;
    assign bus.level        = level_q;
    assign bus.busy         = state_q != IDLE;
    assign bus.overflow     = ovf_q;
endmodule
